// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode constants and the
// baud divisor helper. Imported by uart_tx_cfg and intended for a matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Clock cycles per bit; integer division truncates.
  function automatic int unsigned baud_div(input int unsigned f, input int unsigned baud);
    return f / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: modulo-DIV counter with synchronous clear.
//  clk   in  system clock
//  rst   in  asynchronous active-low reset
//  en    in  count enable; counter holds while low
//  clr   in  synchronous clear to 0 (takes priority over en)
//  tick  out high during the last cycle of each DIV-cycle period
module uart_baud_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  assign tick = en && !clr && (cnt_q == CntMax);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with valid/ready input handshake.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
//  clk    in  system clock
//  rst    in  asynchronous active-low reset
//  data   in  word to send, sampled only on the handshake
//  valid  in  upstream has a word on data
//  ready  out transmitter can accept (idle)
//  tx     out serial line, idle high
//  busy   out frame in progress on the line
//  done   out one-cycle pulse in the final cycle of the last stop bit
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned F         = 50000000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned DIV     = baud_div(F, BAUD);
  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : gen_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gen_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (DIV < 2) begin : gen_bad_div
    $error("uart_tx_cfg: F/BAUD must be at least 2");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic xfer;
  logic tick;
  logic baud_en;
  logic bits_last;
  logic stop_last;

  // ready_q is only ever high in idle, so this is the accept condition.
  assign xfer      = valid && ready_q;
  assign baud_en   = (state_q != StIdle);
  assign bits_last = (bit_cnt_q == BitCntW'(DATA_BITS - 1));
  assign stop_last = (STOP_BITS == 1) || stop_cnt_q;

  // Clearing on accept starts the start bit on a fresh full period; thereafter the
  // counter wraps at each tick, which is the bit boundary.
  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (baud_en),
    .clr  (xfer),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath next values.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          state_d    = StStart;
          shift_d    = data;
          par_d      = (PARITY == PAR_ODD) ? ~^data : ^data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end
      StStart: begin
        if (tick) state_d = StData;
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bits_last) begin
            state_d = (PARITY != PAR_NONE) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      StParity: begin
        if (tick) state_d = StStop;
      end
      StStop: begin
        if (tick) begin
          if (stop_last) begin
            state_d = StIdle;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next values. The line is driven from the current state through a flop, so
  // tx trails the state by one cycle and busy is aligned with tx rather than the FSM.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
      StParity: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == StIdle);
    busy_d  = (state_q != StIdle);
    done_d  = (state_q == StStop) && tick && stop_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
module tb_uart_tx_cfg;

  localparam int unsigned F    = 1000000;
  localparam int unsigned BAUD = 100000;
  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
  logic [7:0] data_n, data_e, data_o;
  logic [6:0] data_7;
  logic valid_n, valid_e, valid_o, valid_7;
  logic ready_n, ready_e, ready_o, ready_7;
  logic tx_n, tx_e, tx_o, tx_7;
  logic busy_n, busy_e, busy_o, busy_7;
  logic done_n, done_e, done_o, done_7;

  uart_tx_cfg #(.F(F), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
    .clk(clk), .rst(rst), .data(data_n), .valid(valid_n), .ready(ready_n),
    .tx(tx_n), .busy(busy_n), .done(done_n));
  uart_tx_cfg #(.F(F), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e (
    .clk(clk), .rst(rst), .data(data_e), .valid(valid_e), .ready(ready_e),
    .tx(tx_e), .busy(busy_e), .done(done_e));
  uart_tx_cfg #(.F(F), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_o (
    .clk(clk), .rst(rst), .data(data_o), .valid(valid_o), .ready(ready_o),
    .tx(tx_o), .busy(busy_o), .done(done_o));
  uart_tx_cfg #(.F(F), .BAUD(BAUD), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7 (
    .clk(clk), .rst(rst), .data(data_7), .valid(valid_7), .ready(ready_7),
    .tx(tx_7), .busy(busy_7), .done(done_7));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic tx_of(input int i);
    case (i)
      0: return tx_n;
      1: return tx_e;
      2: return tx_o;
      default: return tx_7;
    endcase
  endfunction

  function automatic logic done_of(input int i);
    case (i)
      0: return done_n;
      1: return done_e;
      2: return done_o;
      default: return done_7;
    endcase
  endfunction

  function automatic logic ready_of(input int i);
    case (i)
      0: return ready_n;
      1: return ready_e;
      2: return ready_o;
      default: return ready_7;
    endcase
  endfunction

  // Expected frame: line values at each bit mid-point, in transmit order.
  typedef struct {
    int    inst;
    string bits;
    int    fall_cyc;
    bit    abort;
  } exp_t;

  exp_t sb_q[$];

  task automatic drive(input int i, input logic v, input logic [8:0] d);
    case (i)
      0: begin valid_n = v; data_n = d[7:0]; end
      1: begin valid_e = v; data_e = d[7:0]; end
      2: begin valid_o = v; data_o = d[7:0]; end
      default: begin valid_7 = v; data_7 = d[6:0]; end
    endcase
  endtask

  // Called at a negedge with the DUT idle: accept happens on the next edge,
  // start bit appears on the edge after that.
  task automatic send(input int i, input logic [8:0] d, input string bits, input bit ab);
    exp_t e;
    check($sformatf("ready_before_send%0d", i), ready_of(i), 1);
    e.inst     = i;
    e.bits     = bits;
    e.fall_cyc = cyc + 2;
    e.abort    = ab;
    sb_q.push_back(e);
    drive(i, 1'b1, d);
    @(negedge clk);
    drive(i, 1'b0, 9'h1AA);
    check($sformatf("ready_after_accept%0d", i), ready_of(i), 0);
  endtask

  task automatic check_frame(input int i);
    exp_t e;
    int   fc;
    int   nd;
    bit   seen;
    byte  b;
    fc   = cyc;
    nd   = 0;
    seen = 1'b0;
    if (sb_q.size() == 0) begin
      check($sformatf("unexpected_frame%0d", i), 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check("frame_instance", i, e.inst);
    check($sformatf("start_cycle%0d", i), fc, e.fall_cyc);
    if (e.abort) begin
      for (int k = 0; k < 200 && !seen; k++) begin
        @(negedge clk);
        if (done_of(i)) nd++;
        if (!rst) seen = 1'b1;
      end
      check("abort_reset_seen", seen, 1);
      check("abort_tx_idle", tx_of(i), 1);
      check("abort_no_done", nd, 0);
      for (int k = 0; k < 50 && !rst; k++) @(negedge clk);
      return;
    end
    repeat (DIV / 2) @(negedge clk);
    for (int j = 0; j < e.bits.len(); j++) begin
      if (j > 0) repeat (DIV) @(negedge clk);
      b = e.bits[j];
      check($sformatf("inst%0d_bit%0d", i, j), tx_of(i), (b == "1") ? 1 : 0);
    end
    repeat (DIV / 2 - 2) @(negedge clk);
    check($sformatf("inst%0d_done_early", i), done_of(i), 0);
    @(negedge clk);
    check($sformatf("inst%0d_done_pulse", i), done_of(i), 1);
  endtask

  initial begin : monitor
    logic [3:0] prev;
    prev = 4'hF;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (prev[i] && !tx_of(i) && rst) check_frame(i);
      end
      for (int i = 0; i < 4; i++) prev[i] = tx_of(i);
    end
  end

  initial begin : stimulus
    valid_n = 1'b0; valid_e = 1'b0; valid_o = 1'b0; valid_7 = 1'b0;
    data_n = '0; data_e = '0; data_o = '0; data_7 = '0;
    #1 rst = 1'b0;

    // Reset held with valid asserted: nothing may move.
    valid_n = 1'b1; valid_7 = 1'b1; data_n = 8'hFF;
    repeat (5) begin
      @(negedge clk);
      check("rst_tx", tx_n, 1);
      check("rst_ready", ready_n, 1);
      check("rst_busy", busy_n, 0);
      check("rst_done", done_n, 0);
      check("rst_tx7", tx_7, 1);
    end
    valid_n = 1'b0; valid_7 = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // 8N1, 0xD3
    send(0, 9'h0D3, "0110010111", 1'b0);
    repeat (20) @(negedge clk);
    check("busy_mid_8n1", busy_n, 1);
    repeat (90) @(negedge clk);
    check("idle_busy_8n1", busy_n, 0);
    check("idle_ready_8n1", ready_n, 1);

    // Even then odd parity, 0x2C (three ones)
    send(1, 9'h02C, "00011010011", 1'b0);
    repeat (120) @(negedge clk);
    send(2, 9'h02C, "00011010001", 1'b0);
    repeat (120) @(negedge clk);

    // 7 data bits, 2 stop bits, 0x55
    send(3, 9'h055, "0101010111", 1'b0);
    repeat (110) @(negedge clk);
    check("idle_busy_7n2", busy_7, 0);

    // Streaming with valid held: second start follows done by one idle cycle.
    @(negedge clk);
    begin
      exp_t e;
      check("ready_before_stream", ready_n, 1);
      e.inst = 0; e.bits = "0101001011"; e.fall_cyc = cyc + 2; e.abort = 1'b0;
      sb_q.push_back(e);
      e.bits = "0001111001"; e.fall_cyc = cyc + 2 + 10 * DIV + 1;
      sb_q.push_back(e);
    end
    valid_n = 1'b1; data_n = 8'hA5;
    @(negedge clk);
    data_n = 8'h3C;
    repeat (40) @(negedge clk);
    check("stream_ready_low", ready_n, 0);
    check("stream_busy_high", busy_n, 1);
    repeat (61) @(negedge clk);
    valid_n = 1'b0;
    repeat (110) @(negedge clk);

    // Reset in cycle 45 of a frame of 0x00.
    send(0, 9'h000, "", 1'b1);
    repeat (45) @(posedge clk);
    #2;
    check("tx_low_before_abort", tx_n, 0);
    rst = 1'b0;
    #1;
    check("abort_tx_now", tx_n, 1);
    check("abort_busy_now", busy_n, 0);
    check("abort_ready_now", ready_n, 1);
    check("abort_done_now", done_n, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send(0, 9'h081, "0100000011", 1'b0);
    repeat (110) @(negedge clk);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
